// File: rtl/enc8b10b_pkg.sv
// enc8b10b_pkg
// Shared 8b/10b code tables and helpers for the multilane encoder.
// Code groups use a-first bit order: a 6-bit sub-block is {a,b,c,d,e,i} with a
// as the MSB, and a 4-bit sub-block is {f,g,h,j} with f as the MSB.
// Tables hold the RD- form. The RD+ form is the bitwise complement for every
// unbalanced sub-block, and also for the balanced D.7 (111000/000111) and
// D.x.3 (1100/0011) entries.
package enc8b10b_pkg;

  localparam logic [7:0] K28_5      = 8'hBC;
  localparam logic [9:0] K28_5_RDN  = 10'h0FA;
  localparam logic [9:0] K28_5_RDP  = 10'h305;
  localparam logic [3:0] ALT7_RDN   = 4'b0111;

  // 5b/6b data table, RD- column.
  function automatic logic [5:0] enc6_neg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;
      5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;
      5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;
      5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;
      5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;
      5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;
      5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;
      5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;
      5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;
      5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;
      5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b data table (primary D.x.P7 for y=7), RD- column.
  function automatic logic [3:0] enc4_neg(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b1001;
      3'd2: c = 4'b0101;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  // 3b/4b control table for K.28.y, RD- column; RD+ is always the complement.
  function automatic logic [3:0] enc4k_neg(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b0110;
      3'd2: c = 4'b1010;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b0101;
      3'd6: c = 4'b1001;
      default: c = 4'b0111;
    endcase
    return c;
  endfunction

  function automatic logic bal6(input logic [5:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, c[i]};
    return n == 3'd3;
  endfunction

  function automatic logic bal4(input logic [3:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, c[i]};
    return n == 3'd2;
  endfunction

  function automatic logic is_legal_k(input logic [7:0] b);
    logic [4:0] x;
    x = b[4:0];
    return (x == 5'd28) ||
           ((b[7:5] == 3'd7) &&
            ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
  endfunction

  // D.x.A7 avoids a run of five equal bits across the 6b/4b boundary.
  function automatic logic use_a7(input logic [4:0] x, input logic rd);
    if (rd) return (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
    else    return (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
  endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// enc8b10b_lane
// Combinational single-symbol 8b/10b encoder.
// Ports:
//   data   [7:0] input byte, {Y[2:0], X[4:0]}
//   k            control-character flag
//   rd_in        running disparity before this symbol (1 = RD+)
//   code   [9:0] {abcdei, fghj}
//   rd_out       running disparity after this symbol
//   kerr         k set on a byte that is not a legal control character;
//                such bytes are encoded as the D code of the same value
module enc8b10b_lane
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_out,
  output logic       kerr
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k_ok;
  logic       k28;
  logic [5:0] c6_neg;
  logic [5:0] c6;
  logic       cmp6;
  logic       rd_mid;
  logic [3:0] c4_neg;
  logic [3:0] c4;
  logic       cmp4;

  assign x = data[4:0];
  assign y = data[7:5];

  always_comb begin
    k_ok   = k && is_legal_k(data);
    kerr   = k && !k_ok;
    k28    = k_ok && (x == 5'd28);

    c6_neg = k28 ? 6'b001111 : enc6_neg(x);
    cmp6   = !bal6(c6_neg) || (x == 5'd7);
    c6     = (rd_in && cmp6) ? ~c6_neg : c6_neg;
    rd_mid = bal6(c6) ? rd_in : ~rd_in;

    // The 3b/4b choice depends on the disparity left by the 6b sub-block.
    if (k28) begin
      c4_neg = enc4k_neg(y);
      cmp4   = 1'b1;
    end else if ((y == 3'd7) && (k_ok || use_a7(x, rd_mid))) begin
      c4_neg = ALT7_RDN;
      cmp4   = 1'b1;
    end else begin
      c4_neg = enc4_neg(y);
      cmp4   = !bal4(c4_neg) || (y == 3'd3);
    end
    c4     = (rd_mid && cmp4) ? ~c4_neg : c4_neg;
    rd_out = bal4(c4) ? rd_mid : ~rd_mid;

    code   = {c6, c4};
  end

endmodule

// File: rtl/enc8b10b_multilane.sv
// enc8b10b_multilane
// LANES-wide 8b/10b encoder with a two-stage valid/ready pipeline.
// Disparity chains lane 0 -> lane LANES-1 inside a word and is carried between
// words in rd_q. rd_set overrides rd_q; a word encoded in the same cycle still
// uses the old disparity.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   s_data/s_k/s_valid  input word (lane i at s_data[8i+:8]), s_ready back
//   m_data/m_kerr       encoded word (lane i at m_data[10i+:10]) and illegal-K flags
//   m_valid/m_ready     output handshake
//   m_rd                disparity after the last lane of the current output word
//   rd_set/rd_val       disparity override
module enc8b10b_multilane
  import enc8b10b_pkg::*;
#(
  parameter int LANES   = 2,
  parameter bit RD_INIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*LANES-1:0]   s_data,
  input  logic [LANES-1:0]     s_k,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [10*LANES-1:0]  m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [LANES-1:0]     m_kerr,
  output logic                 m_rd,
  input  logic                 rd_set,
  input  logic                 rd_val
);

  logic                 advance;
  logic                 s1_valid;
  logic [8*LANES-1:0]   s1_data;
  logic [LANES-1:0]     s1_k;
  logic                 rd_q;
  logic [LANES:0]       rd_chain;
  logic [10*LANES-1:0]  enc_data;
  logic [LANES-1:0]     enc_kerr;

  // The whole pipeline moves as one; stage 1 can only load when stage 2 drains.
  assign advance = !m_valid || m_ready;
  assign s_ready = advance;

  assign rd_chain[0] = rd_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    enc8b10b_lane u_lane (
      .data   (s1_data[8*i +: 8]),
      .k      (s1_k[i]),
      .rd_in  (rd_chain[i]),
      .code   (enc_data[10*i +: 10]),
      .rd_out (rd_chain[i+1]),
      .kerr   (enc_kerr[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_k     <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_kerr   <= '0;
      m_rd     <= RD_INIT;
    end else if (advance) begin
      s1_valid <= s_valid;
      s1_data  <= s_data;
      s1_k     <= s_k;
      m_valid  <= s1_valid;
      m_data   <= enc_data;
      m_kerr   <= enc_kerr;
      if (s1_valid) m_rd <= rd_chain[LANES];
    end
  end

  // Override wins over the word update; bubbles leave disparity untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rd_q <= RD_INIT;
    else if (rd_set)               rd_q <= rd_val;
    else if (advance && s1_valid)  rd_q <= rd_chain[LANES];
  end

endmodule

// File: tb/tb_enc8b10b_multilane.sv
// Bench for enc8b10b_multilane with LANES=2. Single-lane cases put D21.5 in
// lane 1: it is balanced in both sub-blocks, encodes to 0x2AA from either
// disparity and never changes RD.
module tb_enc8b10b_multilane;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_data;
  logic [1:0]  s_k;
  logic        s_valid;
  logic        s_ready;
  logic [19:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [1:0]  m_kerr;
  logic        m_rd;
  logic        rd_set;
  logic        rd_val;

  int n_chk = 0;
  int n_bad = 0;
  int last_wait = 0;
  logic model_rd;

  always #5 clk = ~clk;

  enc8b10b_multilane #(.LANES(2), .RD_INIT(1'b0)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_k     (s_k),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_kerr  (m_kerr),
    .m_rd    (m_rd),
    .rd_set  (rd_set),
    .rd_val  (rd_val)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-computed symbol table: {kerr, flip, k, byte, code_from_RD-, code_from_RD+}
  function automatic logic [30:0] sym(input int idx);
    case (idx)
      0: return {1'b0, 1'b0, 1'b0, 8'hB5, 10'h2AA, 10'h2AA}; // D21.5
      1: return {1'b0, 1'b1, 1'b1, 8'hBC, 10'h0FA, 10'h305}; // K28.5
      2: return {1'b0, 1'b1, 1'b0, 8'h03, 10'h31B, 10'h314}; // D3.0
      3: return {1'b0, 1'b0, 1'b0, 8'h00, 10'h274, 10'h18B}; // D0.0
      4: return {1'b0, 1'b1, 1'b0, 8'hF1, 10'h237, 10'h231}; // D17.7 (A7 from RD-)
      5: return {1'b0, 1'b1, 1'b0, 8'hEB, 10'h34E, 10'h348}; // D11.7 (A7 from RD+)
      6: return {1'b0, 1'b0, 1'b1, 8'hF7, 10'h3A8, 10'h057}; // K23.7
      default: return {1'b1, 1'b0, 1'b1, 8'h00, 10'h274, 10'h18B}; // illegal K0.0
    endcase
  endfunction

  task automatic send_word(input logic [15:0] d, input logic [1:0] k);
    s_data  = d;
    s_k     = k;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_rd(input logic v);
    rd_set = 1'b1;
    rd_val = v;
    @(negedge clk);
    rd_set = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [19:0] ed,
                             input logic [1:0] ek, input logic er);
    int w;
    w = 0;
    while (m_valid !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    check_val({tag, "_valid"}, {31'd0, m_valid}, 32'd1);
    check_val({tag, "_data"},  {12'd0, m_data}, {12'd0, ed});
    check_val({tag, "_kerr"},  {30'd0, m_kerr}, {30'd0, ek});
    check_val({tag, "_rd"},    {31'd0, m_rd}, {31'd0, er});
    @(negedge clk);
  endtask

  task automatic stream(input int nwords, input bit stall_mode);
    logic [22:0] exp_q[$];
    logic [22:0] e;
    logic [30:0] t0, t1;
    logic [9:0]  c0, c1;
    logic        rd;
    bit          have;
    int          sent, got, cyc, budget;
    sent = 0; got = 0; cyc = 0; have = 1'b0;
    budget = nwords * 5 + 50;
    t0 = '0; t1 = '0;
    while (got < nwords && cyc < budget) begin
      m_ready = stall_mode ? (cyc >= 6) : ($urandom_range(0, 3) != 0);
      if (!have && sent < nwords && (stall_mode || $urandom_range(0, 4) != 0)) begin
        t0 = sym($urandom_range(0, 7));
        t1 = sym($urandom_range(0, 7));
        have = 1'b1;
      end
      s_valid = have;
      s_data  = {t1[27:20], t0[27:20]};
      s_k     = {t1[28], t0[28]};
      #1;
      if (stall_mode && cyc == 5) begin
        check_val("stall_sready", {31'd0, s_ready}, 32'd0);
        check_val("stall_valid", {31'd0, m_valid}, 32'd1);
        if (exp_q.size() > 0)
          check_val("stall_hold", {12'd0, m_data}, {12'd0, exp_q[0][19:0]});
        else
          check_val("stall_queue", 32'd0, 32'd1);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("strm_data", {12'd0, m_data}, {12'd0, e[19:0]});
          check_val("strm_kerr", {30'd0, m_kerr}, {30'd0, e[21:20]});
          check_val("strm_rd",   {31'd0, m_rd}, {31'd0, e[22]});
        end
        got++;
      end
      if (s_valid && s_ready) begin
        rd = model_rd;
        c0 = rd ? t0[9:0] : t0[19:10];
        rd = rd ^ t0[29];
        c1 = rd ? t1[9:0] : t1[19:10];
        rd = rd ^ t1[29];
        model_rd = rd;
        exp_q.push_back({rd, t1[30], t0[30], c1, c0});
        have = 1'b0;
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check_val(stall_mode ? "stall_count" : "rand_count", got, nwords);
    check_val(stall_mode ? "stall_left" : "rand_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ghost;
    rst_n   = 1'b0;
    s_data  = '0;
    s_k     = '0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    rd_set  = 1'b0;
    rd_val  = 1'b0;
    model_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_valid", {31'd0, m_valid}, 32'd0);
    check_val("rst_rd",    {31'd0, m_rd}, 32'd0);
    check_val("rst_data",  {12'd0, m_data}, 32'd0);
    check_val("rst_kerr",  {30'd0, m_kerr}, 32'd0);
    check_val("rst_sready",{31'd0, s_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    send_word({8'hB5, 8'hBC}, 2'b00 | 2'b01);
    expect_word("k285_neg", {10'h2AA, 10'h0FA}, 2'b00, 1'b1);
    check_val("latency", last_wait, 32'd1);
    send_word({8'hB5, 8'hBC}, 2'b01);
    expect_word("k285_pos", {10'h2AA, 10'h305}, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_word({8'hB5, 8'hB5}, 2'b00);
      expect_word("d215", {10'h2AA, 10'h2AA}, 2'b00, 1'b0);
    end
    send_word({8'hB5, 8'h03}, 2'b00);
    expect_word("d30_neg", {10'h2AA, 10'h31B}, 2'b00, 1'b1);
    send_word({8'hB5, 8'h03}, 2'b00);
    expect_word("d30_pos", {10'h2AA, 10'h314}, 2'b00, 1'b0);
    send_word({8'hBC, 8'h03}, 2'b10);
    expect_word("chain", {10'h305, 10'h31B}, 2'b00, 1'b0);
    send_word({8'hB5, 8'h00}, 2'b01);
    expect_word("bad_k", {10'h2AA, 10'h274}, 2'b01, 1'b0);

    pulse_rd(1'b1);
    send_word({8'hB5, 8'h03}, 2'b00);
    expect_word("rdset_idle", {10'h2AA, 10'h314}, 2'b00, 1'b0);
    send_word({8'hB5, 8'hBC}, 2'b01);
    pulse_rd(1'b0);
    expect_word("rdset_same", {10'h2AA, 10'h0FA}, 2'b00, 1'b1);
    send_word({8'hB5, 8'hBC}, 2'b01);
    expect_word("rdset_after", {10'h2AA, 10'h0FA}, 2'b00, 1'b1);

    model_rd = 1'b1;
    stream(8, 1'b1);
    stream(10000, 1'b0);

    pulse_rd(1'b1);
    send_word({8'hB5, 8'hB5}, 2'b00);
    expect_word("pre_rst", {10'h2AA, 10'h2AA}, 2'b00, 1'b1);
    m_ready = 1'b0;
    send_word({8'hB5, 8'hBC}, 2'b01);
    send_word({8'hB5, 8'hBC}, 2'b01);
    @(negedge clk);
    check_val("pre_rst_full", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_valid", {31'd0, m_valid}, 32'd0);
    check_val("midrst_rd",    {31'd0, m_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    ghost = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_valid) ghost++;
    end
    check_val("no_ghost", ghost, 32'd0);
    send_word({8'hB5, 8'hBC}, 2'b01);
    expect_word("post_rst", {10'h2AA, 10'h0FA}, 2'b00, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
